// File: rtl/radix2_divider.sv
`default_nettype none
// ============================================================================
// Module      : radix2_divider
// Description : Sequential radix-2 restoring divider, signed/unsigned, with
//               single-cycle handling of divide-by-zero and signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module radix2_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 7
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_DIV,
    input  logic             ctrl_signed,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_quotient,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] C_MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] C_LAST_STEP = CNT_W'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   rq_q, rq_d;
    logic [WIDTH-1:0]     div_q, div_d;
    logic                 signed_q, signed_d;
    logic                 sign_a_q, sign_a_d;
    logic                 sign_b_q, sign_b_d;
    logic [WIDTH-1:0]     quot_q, quot_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic                 exc_q, exc_d;
    logic                 rdy_q, rdy_d;
    logic                 busy_q, busy_d;

    logic [WIDTH:0]       trial;
    logic [WIDTH:0]       diff;
    logic [2*WIDTH-1:0]   step_rq;
    logic [WIDTH-1:0]     q_mag;
    logic [WIDTH-1:0]     r_mag;
    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;

    // One restoring step: the top bit of the WIDTH+1-bit difference is the borrow.
    always_comb begin
        trial   = rq_q[2*WIDTH-1:WIDTH-1];
        diff    = trial - {1'b0, div_q};
        step_rq = diff[WIDTH] ? {rq_q[2*WIDTH-2:0], 1'b0}
                              : {diff[WIDTH-1:0], rq_q[WIDTH-2:0], 1'b1};
        q_mag   = step_rq[WIDTH-1:0];
        r_mag   = step_rq[2*WIDTH-1:WIDTH];
        abs_a   = (ctrl_signed && data_operandA[WIDTH-1]) ? -data_operandA : data_operandA;
        abs_b   = (ctrl_signed && data_operandB[WIDTH-1]) ? -data_operandB : data_operandB;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rq_d     = rq_q;
        div_d    = div_q;
        signed_d = signed_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;

        case (state_q)
            S_CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                rq_d  = step_rq;
                if (cnt_q == C_LAST_STEP) begin
                    state_d = S_DONE;
                    quot_d  = (signed_q && (sign_a_q ^ sign_b_q)) ? -q_mag : q_mag;
                    rem_d   = (signed_q && sign_a_q) ? -r_mag : r_mag;
                    exc_d   = 1'b0;
                    rdy_d   = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A start in any state wins, aborting whatever was in flight.
        if (ctrl_DIV) begin
            signed_d = ctrl_signed;
            sign_a_d = data_operandA[WIDTH-1];
            sign_b_d = data_operandB[WIDTH-1];
            rq_d     = {{WIDTH{1'b0}}, abs_a};
            div_d    = abs_b;
            cnt_d    = '0;
            if (data_operandB == '0) begin
                state_d = S_DONE;
                quot_d  = '1;
                rem_d   = data_operandA;
                exc_d   = 1'b1;
                rdy_d   = 1'b1;
            end else if (ctrl_signed && (data_operandA == C_MOST_NEG) && (data_operandB == '1)) begin
                state_d = S_DONE;
                quot_d  = C_MOST_NEG;
                rem_d   = '0;
                exc_d   = 1'b1;
                rdy_d   = 1'b1;
            end else begin
                state_d = S_CALC;
                rdy_d   = 1'b0;
            end
        end

        busy_d = (state_d == S_CALC);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rq_q     <= '0;
            div_q    <= '0;
            signed_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            quot_q   <= '0;
            rem_q    <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rq_q     <= rq_d;
            div_q    <= div_d;
            signed_q <= signed_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
        end
    end

    assign data_quotient  = quot_q;
    assign data_remainder = rem_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_radix2_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_radix2_divider
// Description : Directed self-checking bench for radix2_divider (WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_radix2_divider;

    localparam int WIDTH = 32;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             ctrl_DIV = 1'b0;
    logic             ctrl_signed = 1'b0;
    logic [WIDTH-1:0] data_operandA = '0;
    logic [WIDTH-1:0] data_operandB = '0;
    logic [WIDTH-1:0] data_quotient;
    logic [WIDTH-1:0] data_remainder;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    int checks = 0;
    int errors = 0;

    radix2_divider #(.WIDTH(WIDTH), .CNT_W(7)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_DIV       (ctrl_DIV),
        .ctrl_signed    (ctrl_signed),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_quotient  (data_quotient),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    // Returns 1 ns after the start edge (edge 1).
    task automatic start_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b, input logic sgn);
        @(negedge clock);
        data_operandA = op_a;
        data_operandB = op_b;
        ctrl_signed   = sgn;
        ctrl_DIV      = 1'b1;
        @(posedge clock);
        #1;
        ctrl_DIV      = 1'b0;
    endtask

    // Counts edges from the start edge (edge 1) until data_resultRDY, bounded.
    task automatic wait_rdy(output int edges);
        edges = 1;
        while (!data_resultRDY && edges < 100) begin
            @(posedge clock);
            #1;
            edges++;
        end
    endtask

    task automatic test_reset;
        int e;
        #12;
        checks++;
        if ({data_quotient, data_remainder, data_exception, data_resultRDY, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got q=%h r=%h exc=%b rdy=%b busy=%b expected all 0",
                     data_quotient, data_remainder, data_exception, data_resultRDY, busy);
        end
        // Start is presented together with reset release.
        @(negedge clock);
        reset_n       = 1'b1;
        data_operandA = 32'd20;
        data_operandB = 32'd3;
        ctrl_signed   = 1'b0;
        ctrl_DIV      = 1'b1;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        wait_rdy(e);
        checks++;
        if (e !== 33) begin
            errors++;
            $display("FAIL first_start_latency: got %0d expected 33", e);
        end
        checks++;
        if (data_quotient !== 32'd6 || data_remainder !== 32'd2) begin
            errors++;
            $display("FAIL first_start_result: got q=%h r=%h expected q=6 r=2", data_quotient, data_remainder);
        end
    endtask

    task automatic test_unsigned_latency;
        int e;
        int busy_cnt;
        start_op(32'd100, 32'd7, 1'b0);
        e = 1;
        busy_cnt = 0;
        while (!data_resultRDY && e < 100) begin
            if (busy) busy_cnt++;
            @(posedge clock);
            #1;
            e++;
        end
        checks++;
        if (e !== 33) begin
            errors++;
            $display("FAIL u100_7_latency: got %0d expected 33", e);
        end
        checks++;
        if (busy_cnt !== 32) begin
            errors++;
            $display("FAIL u100_7_busy_cycles: got %0d expected 32", busy_cnt);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL u100_7_busy_at_rdy: got %b expected 0", busy);
        end
        checks++;
        if (data_quotient !== 32'd14 || data_remainder !== 32'd2 || data_exception !== 1'b0) begin
            errors++;
            $display("FAIL u100_7_result: got q=%h r=%h exc=%b expected q=e r=2 exc=0",
                     data_quotient, data_remainder, data_exception);
        end
        @(posedge clock);
        #1;
        checks++;
        if (data_resultRDY !== 1'b0 || data_quotient !== 32'd14 || data_remainder !== 32'd2) begin
            errors++;
            $display("FAIL u100_7_hold: got rdy=%b q=%h r=%h expected rdy=0 q=e r=2",
                     data_resultRDY, data_quotient, data_remainder);
        end
    endtask

    task automatic test_signed;
        logic [WIDTH-1:0] va [4] = '{32'hFFFF_FFF9, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FF9C};
        logic [WIDTH-1:0] vb [4] = '{32'd2,         32'hFFFF_FFFE, 32'd2,         32'hFFFF_FFF9};
        logic             vs [4] = '{1'b1,          1'b1,          1'b0,          1'b1};
        logic [WIDTH-1:0] eq [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h7FFF_FFFF, 32'd14};
        logic [WIDTH-1:0] er [4] = '{32'hFFFF_FFFF, 32'd1,         32'd1,         32'hFFFF_FFFE};
        int e;
        for (int i = 0; i < 4; i++) begin
            start_op(va[i], vb[i], vs[i]);
            wait_rdy(e);
            checks++;
            if (e !== 33) begin
                errors++;
                $display("FAIL div_vec%0d_latency: got %0d expected 33", i, e);
            end
            checks++;
            if (data_quotient !== eq[i] || data_remainder !== er[i] || data_exception !== 1'b0) begin
                errors++;
                $display("FAIL div_vec%0d_result: got q=%h r=%h exc=%b expected q=%h r=%h exc=0",
                         i, data_quotient, data_remainder, data_exception, eq[i], er[i]);
            end
        end
    endtask

    task automatic test_div_zero;
        int e;
        start_op(32'h1234_5678, 32'd0, 1'b0);
        wait_rdy(e);
        checks++;
        if (e !== 1) begin
            errors++;
            $display("FAIL divzero_latency: got %0d expected 1", e);
        end
        checks++;
        if (data_quotient !== 32'hFFFF_FFFF || data_remainder !== 32'h1234_5678 || data_exception !== 1'b1) begin
            errors++;
            $display("FAIL divzero_result: got q=%h r=%h exc=%b expected q=ffffffff r=12345678 exc=1",
                     data_quotient, data_remainder, data_exception);
        end
        @(posedge clock);
        #1;
        checks++;
        if (data_resultRDY !== 1'b0 || data_exception !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL divzero_hold: got rdy=%b exc=%b busy=%b expected rdy=0 exc=1 busy=0",
                     data_resultRDY, data_exception, busy);
        end
    endtask

    task automatic test_overflow;
        int e;
        start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_rdy(e);
        checks++;
        if (e !== 1) begin
            errors++;
            $display("FAIL ovf_latency: got %0d expected 1", e);
        end
        checks++;
        if (data_quotient !== 32'h8000_0000 || data_remainder !== 32'd0 || data_exception !== 1'b1) begin
            errors++;
            $display("FAIL ovf_result: got q=%h r=%h exc=%b expected q=80000000 r=0 exc=1",
                     data_quotient, data_remainder, data_exception);
        end
        // Same bit patterns unsigned are an ordinary division.
        start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_rdy(e);
        checks++;
        if (e !== 33) begin
            errors++;
            $display("FAIL ovf_unsigned_latency: got %0d expected 33", e);
        end
        checks++;
        if (data_quotient !== 32'd0 || data_remainder !== 32'h8000_0000 || data_exception !== 1'b0) begin
            errors++;
            $display("FAIL ovf_unsigned_result: got q=%h r=%h exc=%b expected q=0 r=80000000 exc=0",
                     data_quotient, data_remainder, data_exception);
        end
    endtask

    task automatic test_abort;
        int e;
        logic seen;
        seen = 1'b0;
        start_op(32'd100, 32'd7, 1'b0);
        repeat (8) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) seen = 1'b1;
        end
        start_op(32'd50, 32'd5, 1'b0);
        wait_rdy(e);
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL abort_early_rdy: got %b expected 0", seen);
        end
        checks++;
        if (e !== 33) begin
            errors++;
            $display("FAIL abort_latency: got %0d expected 33", e);
        end
        checks++;
        if (data_quotient !== 32'd10 || data_remainder !== 32'd0) begin
            errors++;
            $display("FAIL abort_result: got q=%h r=%h expected q=a r=0", data_quotient, data_remainder);
        end
    endtask

    task automatic test_back_to_back;
        int e;
        start_op(32'd9, 32'd2, 1'b0);
        wait_rdy(e);
        checks++;
        if (e !== 33 || data_quotient !== 32'd4 || data_remainder !== 32'd1) begin
            errors++;
            $display("FAIL b2b_first: got lat=%0d q=%h r=%h expected lat=33 q=4 r=1",
                     e, data_quotient, data_remainder);
        end
        // New start presented during the DONE cycle.
        data_operandA = 32'd45;
        data_operandB = 32'd6;
        ctrl_signed   = 1'b0;
        ctrl_DIV      = 1'b1;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        checks++;
        if (busy !== 1'b1 || data_resultRDY !== 1'b0) begin
            errors++;
            $display("FAIL b2b_restart: got busy=%b rdy=%b expected busy=1 rdy=0", busy, data_resultRDY);
        end
        wait_rdy(e);
        checks++;
        if (e !== 33 || data_quotient !== 32'd7 || data_remainder !== 32'd3) begin
            errors++;
            $display("FAIL b2b_second: got lat=%0d q=%h r=%h expected lat=33 q=7 r=3",
                     e, data_quotient, data_remainder);
        end
    endtask

    task automatic test_reset_mid;
        int e;
        logic seen;
        seen = 1'b0;
        start_op(32'd100, 32'd7, 1'b0);
        repeat (13) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) seen = 1'b1;
        end
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({data_quotient, data_remainder, data_exception, data_resultRDY, busy} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got q=%h r=%h exc=%b rdy=%b busy=%b expected all 0",
                     data_quotient, data_remainder, data_exception, data_resultRDY, busy);
        end
        repeat (2) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) seen = 1'b1;
        end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_discard: got rdy_seen=%b busy=%b expected 0 0", seen, busy);
        end
        start_op(32'd1000, 32'd10, 1'b0);
        wait_rdy(e);
        checks++;
        if (e !== 33 || data_quotient !== 32'd100 || data_remainder !== 32'd0 || data_exception !== 1'b0) begin
            errors++;
            $display("FAIL midreset_restart: got lat=%0d q=%h r=%h exc=%b expected lat=33 q=64 r=0 exc=0",
                     e, data_quotient, data_remainder, data_exception);
        end
    endtask

    initial begin
        test_reset;
        test_unsigned_latency;
        test_signed;
        test_div_zero;
        test_overflow;
        test_abort;
        test_back_to_back;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
